// File: rtl/aes_inv_subword.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_subword
// Brief   : Byte-serial AES InvSubWord; one composite-field inverse S-box
//           evaluation per clock, four cycles per 32-bit word.
// Revision: 1.0
// ============================================================================
module aes_inv_subword (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // GF(2^4) field constant lambda for the tower z^2 + z + lambda
  localparam logic [3:0] LAMBDA = 4'hC;

  // GF(2^2) in basis {x, 1} with x^2 = x + 1; phi = x
  function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
    gf2_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
               (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf2_sq(input logic [1:0] a);
    gf2_sq = {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] gf2_scl_phi(input logic [1:0] a);
    gf2_scl_phi = {a[1] ^ a[0], a[1]};
  endfunction

  // GF(2^4) = GF(2^2)[y] / (y^2 + y + phi)
  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    hh      = gf2_mul(a[3:2], b[3:2]);
    gf4_mul = {hh ^ gf2_mul(a[3:2], b[1:0]) ^ gf2_mul(a[1:0], b[3:2]),
               gf2_scl_phi(hh) ^ gf2_mul(a[1:0], b[1:0])};
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    logic [1:0] hs;
    hs     = gf2_sq(a[3:2]);
    gf4_sq = {hs, gf2_scl_phi(hs) ^ gf2_sq(a[1:0])};
  endfunction

  function automatic logic [3:0] gf4_scl_lambda(input logic [3:0] a);
    gf4_scl_lambda = gf4_mul(a, LAMBDA);
  endfunction

  // Inverse via the GF(2^2) norm; in GF(2^2) e^-1 = e^2 (and 0 maps to 0)
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [1:0] e;
    logic [1:0] ei;
    e       = gf2_scl_phi(gf2_sq(a[3:2])) ^ gf2_mul(a[3:2], a[1:0]) ^ gf2_sq(a[1:0]);
    ei      = gf2_sq(e);
    gf4_inv = {gf2_mul(a[3:2], ei), gf2_mul(a[3:2] ^ a[1:0], ei)};
  endfunction

  function automatic logic [7:0] gf8_inv(input logic [7:0] a);
    logic [3:0] d;
    logic [3:0] di;
    d       = gf4_scl_lambda(gf4_sq(a[7:4])) ^ gf4_mul(a[7:4], a[3:0]) ^ gf4_sq(a[3:0]);
    di      = gf4_inv(d);
    gf8_inv = {gf4_mul(a[7:4], di), gf4_mul(a[7:4] ^ a[3:0], di)};
  endfunction

  // Isomorphism between the AES polynomial basis and the tower field
  function automatic logic [7:0] map_in(input logic [7:0] x);
    map_in = {x[7] ^ x[5],
              x[7] ^ x[6] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
              x[7] ^ x[5] ^ x[3] ^ x[2],
              x[7] ^ x[5] ^ x[3] ^ x[2] ^ x[1],
              x[7] ^ x[6] ^ x[2] ^ x[1],
              x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
              x[6] ^ x[4] ^ x[1],
              x[6] ^ x[1] ^ x[0]};
  endfunction

  function automatic logic [7:0] map_out(input logic [7:0] x);
    map_out = {x[7] ^ x[6] ^ x[5] ^ x[1],
               x[6] ^ x[2],
               x[6] ^ x[5] ^ x[1],
               x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[1],
               x[5] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
               x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1],
               x[5] ^ x[4],
               x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[0]};
  endfunction

  // Inverse affine first, then field inversion
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y        = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    inv_sbox = map_out(gf8_inv(map_in(y)));
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] out_word_q, out_word_d;
  logic        out_valid_q, out_valid_d;
  logic        accept;
  logic [4:0]  byte_lsb;
  logic [7:0]  byte_inv;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == BUSY);
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign byte_lsb  = {cnt_q, 3'b000};
  assign byte_inv  = inv_sbox(word_q[byte_lsb +: 8]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          word_d  = in_word;
          cnt_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        out_word_d[byte_lsb +: 8] = byte_inv;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            word_d  = in_word;
            cnt_d   = 2'd0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      word_q      <= 32'd0;
      out_word_q  <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_subword.sv
`default_nettype none
// Testbench for aes_inv_subword: directed words, expected results queued at
// issue time and compared by an independent output monitor.
module tb_aes_inv_subword;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] in_word = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;

  always #5 clk = ~clk;

  aes_inv_subword dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_word   (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  localparam logic [7:0] INV_TBL [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] in_q[$];
  int          acc_q[$];
  int          rise_q[$];
  bit          ov_seen = 1'b0;
  logic [31:0] held;
  logic [31:0] mon_in;
  int          mon_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Forward S-box reference in the plain polynomial basis
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = a;
    for (int i = 0; i < 253; i++) r = gmul(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !ov_seen) begin
        ov_seen = 1'b1;
        held    = out_word;
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h, required no output", out_word);
        end else begin
          check("result", out_word, exp_q.pop_front());
          mon_in = in_q.pop_front();
          check("sbox_roundtrip", {sbox(out_word[31:24]), sbox(out_word[23:16]),
                                   sbox(out_word[15:8]), sbox(out_word[7:0])}, mon_in);
          mon_acc = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
          check("latency", 32'(cyc - mon_acc), 32'd4);
        end
      end else if (out_valid) begin
        check("hold_stable", out_word, held);
      end
      if (out_valid && out_ready) ov_seen = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [31:0] w, input logic [31:0] e);
    int n = 0;
    exp_q.push_back(e);
    in_q.push_back(w);
    in_word  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    int n;
    logic [31:0] w;
    logic [31:0] e;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word, accepted on the first edge after reset
    send(32'h16ED7C63, 32'hFF530100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      check("busy_flag", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    @(negedge clk);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Zero and one
    send(32'h00000000, 32'h52525252);
    send(32'h52525252, 32'h48484848);
    drain();

    // Backpressure with a second word waiting
    out_ready = 1'b0;
    send(32'h01020304, 32'h096AD530);
    exp_q.push_back(32'h01000100);
    in_q.push_back(32'h7C637C63);
    in_word  = 32'h7C637C63;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      if (i < 9) @(negedge clk);
    end
    check("bp_no_accept", 32'(acc_q.size()), 32'd0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Back-to-back
    r0 = rise_q.size();
    send(32'h00010203, 32'h52096AD5);
    send(32'h10203040, 32'h7C540872);
    send(32'hF0E0D0C0, 32'h17A0601F);
    drain();
    if (rise_q.size() >= r0 + 3) begin
      check("b2b_interval1", 32'(rise_q[r0 + 1] - rise_q[r0]), 32'd5);
      check("b2b_interval2", 32'(rise_q[r0 + 2] - rise_q[r0 + 1]), 32'd5);
    end else begin
      check("b2b_results", 32'(rise_q.size() - r0), 32'd3);
    end

    // Reset in the middle of BUSY (cnt = 2)
    send(32'hAAAAAAAA, 32'h62626262);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_word", out_word, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    in_q.delete();
    acc_q.delete();
    ov_seen = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'h8C8C8C8C, 32'hF0F0F0F0);
    drain();

    // All 256 byte values, four per word
    for (int k = 0; k < 64; k++) begin
      for (int b = 0; b < 4; b++) begin
        w[8*b +: 8] = 8'(4*k + b);
        e[8*b +: 8] = INV_TBL[4*k + b];
      end
      send(w, e);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
